// File: rtl/cpu_assoc_cache.sv
// N-way set-associative write-back/write-allocate data cache with per-set round-robin victims.
// Optional hit/miss counters are compiled in when CPU_CACHE_STATS_EN is defined.
module cpu_assoc_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_data,
  output logic                  resp_hit,
  output logic [WORD_WIDTH-1:0] resp_data,
  input  logic                  mem_bus_available,
  output logic                  mem_bus_read,
  output logic                  mem_bus_write,
  output logic [ADDR_WIDTH-1:0] mem_bus_addr,
  output logic [LINE_WIDTH-1:0] mem_bus_wdata,
  input  logic                  mem_bus_resp_valid,
  input  logic [ADDR_WIDTH-1:0] mem_bus_resp_addr,
  input  logic [LINE_WIDTH-1:0] mem_bus_resp_data,
  output logic [1:0]            dbg_state_o
`ifdef CPU_CACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
`endif
);

  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int WOFF_W = $clog2(WORD_WIDTH / 8);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EVICT     = 2'd1,
    ST_FILL_REQ  = 2'd2,
    ST_FILL_WAIT = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                  valid_q [NUM_SETS][NUM_WAYS];
  logic                  dirty_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_WIDTH-1:0] line_q  [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]      vptr_q  [NUM_SETS];

  // Line-aligned address of the outstanding miss and the way it will land in.
  logic [ADDR_WIDTH-1:0] miss_addr_q;
  logic [WAY_W-1:0]      victim_q;

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [OFF_W-1:0]      req_off;
  logic [OFF_W-1:0]      word_sel;
  logic                  access;
  logic                  hit_any;
  logic [WAY_W-1:0]      hit_way;
  logic                  inv_found;
  logic [WAY_W-1:0]      inv_way;
  logic [WAY_W-1:0]      vic_way;
  logic [LINE_WIDTH-1:0] hit_line;
  logic [WORD_WIDTH-1:0] rd_word;
  logic [7:0]            rd_byte;
  logic [LINE_WIDTH-1:0] st_mask;
  logic [LINE_WIDTH-1:0] st_bits;
  logic [LINE_WIDTH-1:0] st_line;
  logic                  miss_start;
  logic [IDX_W-1:0]      miss_idx;
  logic [ADDR_WIDTH-1:0] ev_addr;
  logic                  fill_ok;
  logic                  evict_fire;
  logic [WAY_W-1:0]      vptr_next;

  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_off  = req_addr[OFF_W-1:0];
  assign word_sel = req_off >> WOFF_W;
  assign access   = req_read | req_write;

  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign vic_way  = inv_found ? inv_way : vptr_q[req_idx];
  assign hit_line = line_q[req_idx][hit_way];
  assign rd_word  = WORD_WIDTH'(hit_line >> (word_sel * WORD_WIDTH));
  assign rd_byte  = 8'(hit_line >> {req_off, 3'b000});

  // Store merge: only the addressed word or byte lane is replaced.
  always_comb begin
    st_mask = '0;
    st_bits = '0;
    if (req_mode) begin
      st_mask = LINE_WIDTH'(8'hFF) << {req_off, 3'b000};
      st_bits = LINE_WIDTH'(req_data[7:0]) << {req_off, 3'b000};
    end else begin
      st_mask = LINE_WIDTH'({WORD_WIDTH{1'b1}}) << (word_sel * WORD_WIDTH);
      st_bits = LINE_WIDTH'(req_data) << (word_sel * WORD_WIDTH);
    end
    st_line = (hit_line & ~st_mask) | (st_bits & st_mask);
  end

  assign resp_hit  = (state_q == ST_IDLE) && access && hit_any;
  assign resp_data = !resp_hit ? '0 :
                     req_mode  ? {{(WORD_WIDTH-8){1'b0}}, rd_byte} : rd_word;

  assign miss_idx   = miss_addr_q[OFF_W +: IDX_W];
  assign ev_addr    = {tag_q[miss_idx][victim_q], miss_idx, {OFF_W{1'b0}}};
  assign fill_ok    = (state_q == ST_FILL_WAIT) && mem_bus_resp_valid &&
                      (mem_bus_resp_addr == miss_addr_q);
  assign evict_fire = (state_q == ST_EVICT) && mem_bus_available;
  assign vptr_next  = (vptr_q[miss_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 :
                      vptr_q[miss_idx] + 1'b1;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d       = state_q;
    miss_start    = 1'b0;
    mem_bus_read  = 1'b0;
    mem_bus_write = 1'b0;
    mem_bus_addr  = '0;
    mem_bus_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (access && !hit_any) begin
          miss_start = 1'b1;
          state_d    = (valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way]) ?
                       ST_EVICT : ST_FILL_REQ;
        end
      end
      ST_EVICT: begin
        if (mem_bus_available) begin
          mem_bus_write = 1'b1;
          mem_bus_addr  = ev_addr;
          mem_bus_wdata = line_q[miss_idx][victim_q];
          state_d       = ST_FILL_REQ;
        end
      end
      ST_FILL_REQ: begin
        if (mem_bus_available) begin
          mem_bus_read = 1'b1;
          mem_bus_addr = miss_addr_q;
          state_d      = ST_FILL_WAIT;
        end
      end
      ST_FILL_WAIT: begin
        if (fill_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      miss_addr_q <= '0;
      victim_q    <= '0;
    end else if (miss_start) begin
      miss_addr_q <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      victim_q    <= vic_way;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        vptr_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
      end
    end else begin
      if (resp_hit && req_write) dirty_q[req_idx][hit_way] <= 1'b1;
      if (evict_fire) valid_q[miss_idx][victim_q] <= 1'b0;
      if (fill_ok) begin
        valid_q[miss_idx][victim_q] <= 1'b1;
        dirty_q[miss_idx][victim_q] <= 1'b0;
        vptr_q[miss_idx]            <= vptr_next;
      end
    end
  end

  // Tag and data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clock) begin
    if (resp_hit && req_write) line_q[req_idx][hit_way] <= st_line;
    if (fill_ok) begin
      line_q[miss_idx][victim_q] <= mem_bus_resp_data;
      tag_q[miss_idx][victim_q]  <= miss_addr_q[ADDR_WIDTH-1 -: TAG_W];
    end
  end

`ifdef CPU_CACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (resp_hit && (hits_q != 32'hFFFF_FFFF))     hits_q   <= hits_q + 32'd1;
      if (miss_start && (misses_q != 32'hFFFF_FFFF)) misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: doc/cpu_assoc_cache.md
# cpu_assoc_cache

Parametrised N-way set-associative, write-back, write-allocate data cache sitting between the CPU load/store stage and the shared memory bus. Replaces the direct-mapped CPU cache: generalises sets, ways and line width, adds dirty-line eviction and per-set round-robin replacement. Hits are answered combinationally; misses run a bus-arbitrated fill, preceded by a write-back if the victim is dirty.

## Interface
- ADDR_WIDTH, 32, byte address width
- WORD_WIDTH, 32, CPU data width
- LINE_WIDTH, 128, line/bus data width; power of two, multiple of WORD_WIDTH
- NUM_SETS, 4, sets; power of two, ≥2
- NUM_WAYS, 2, ways per set; power of two, ≥1
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_read  in  1  load request
- req_write  in  1  store request; wins if asserted together with req_read
- req_mode  in  1  0 = WORD, 1 = BYTE
- req_addr  in  ADDR_WIDTH  byte address; WORD mode ignores addr[1:0]
- req_data  in  WORD_WIDTH  store data; BYTE mode uses [7:0]
- resp_hit  out  1  request satisfied this cycle
- resp_data  out  WORD_WIDTH  load data; BYTE mode zero-extended
- mem_bus_available  in  1  arbiter grant; bus request may issue only while high
- mem_bus_read  out  1  one-cycle line read pulse
- mem_bus_write  out  1  one-cycle line write-back pulse
- mem_bus_addr  out  ADDR_WIDTH  line-aligned address
- mem_bus_wdata  out  LINE_WIDTH  victim line data
- mem_bus_resp_valid  in  1  fill data valid
- mem_bus_resp_addr  in  ADDR_WIDTH  fill line address
- mem_bus_resp_data  in  LINE_WIDTH  fill line

## Operation
- Address split: offset = log2(LINE_WIDTH/8) LSBs, index = next log2(NUM_SETS) bits, tag = rest. Per way: valid, dirty, tag, line. Per set: victim pointer (log2(NUM_WAYS) bits).
- Byte lanes little-endian: byte at offset k occupies line bits [8k+7:8k].
- FSM states: IDLE, EVICT, FILL_REQ, FILL_WAIT.
- IDLE: lookup compares tag across all valid ways of the indexed set. Hit → resp_hit=1; load returns selected word/byte; store writes word or byte lane and sets dirty at the same edge. Miss → pick victim: lowest-index invalid way, else victim pointer. Victim valid and dirty → EVICT, else → FILL_REQ.
- EVICT: when mem_bus_available, pulse mem_bus_write one cycle with victim tag/index address and line; clear victim valid; → FILL_REQ. Write is posted (no ack).
- FILL_REQ: when mem_bus_available, pulse mem_bus_read one cycle, line-aligned request address; → FILL_WAIT.
- FILL_WAIT: on mem_bus_resp_valid with mem_bus_resp_addr equal to the requested line address, write line into victim way, valid=1, dirty=0, tag set, increment set's victim pointer (wraps at NUM_WAYS); → IDLE. Mismatching address ignored.
- Request held by CPU until resp_hit; request changes during a miss are ignored until IDLE.
- resp_data = 0 whenever resp_hit = 0.

## Timing
- Reset: all valid/dirty cleared, victim pointers 0, FSM IDLE, resp_hit, mem_bus_read, mem_bus_write = 0, mem_bus_addr, mem_bus_wdata = 0.
- Hit latency 0 cycles (combinational from request and arrays); store committed at that edge.
- Clean miss: request at cycle N → mem_bus_read high during N+1 if bus available at N+1 (later if not); fill accepted at edge of valid response cycle M → resp_hit at M+1.
- Dirty miss: adds one mem_bus_write cycle, then mem_bus_read the following bus-available cycle.
- mem_bus_read/write never both high; each high exactly one cycle per transaction.
- Reset mid-miss: FSM → IDLE, fill dropped; later responses ignored (accepted only in FILL_WAIT).
- No request (read=write=0): FSM stays IDLE, no bus activity.

## Configuration
- CPU_CACHE_STATS_EN defined: adds outputs stat_hits and stat_misses (32-bit each, saturating at 0xFFFFFFFF, reset 0). stat_hits increments on each cycle with resp_hit=1; stat_misses on each IDLE→EVICT/FILL_REQ transition.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset; read WORD 0x0 with bus unavailable 1 cycle → no bus pulse; grant → mem_bus_read pulse, addr 0x0; respond 128'hDDDDDDDDCCCCCCCCBBBBBBBBAAAAAAAA → next cycle hit, data 0xAAAAAAAA; addr 0x4 → 0xBBBBBBBB, 0xC → 0xDDDDDDDD, no bus traffic.
- Write WORD 0x11223344 at 0x8 → hit same cycle; read 0x8 → 0x11223344.
- Write BYTE 0x55 at 0x9 → read WORD 0x8 → 0x11225544; read BYTE 0x9 → 0x00000055.
- Fill 0x40 (set 0, way 1), then read 0x80 → mem_bus_write pulse addr 0x0 with modified line, then mem_bus_read addr 0x80; afterwards 0x40 still hits, 0x0 misses.
- Reset during FILL_WAIT, then assert response for 0x0 → ignored; read 0x0 → miss, new mem_bus_read.
- With CPU_CACHE_STATS_EN: scenario 1 sequence → stat_misses=1, stat_hits=3.
